// File: rtl/img_mem_pkg.sv
// rtl/img_mem_pkg.sv - shared types, defaults and address helper for the image buffer addressers
package img_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCEPT = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int PIX_W_DEF = 8;

    // Planes are stored back to back, rows within a plane, columns within a row.
    function automatic int unsigned lin_addr(
        input int unsigned chan,
        input int unsigned row,
        input int unsigned col,
        input int unsigned img_w,
        input int unsigned img_h
    );
        return chan * img_w * img_h + row * img_w + col;
    endfunction

endpackage

// File: rtl/img_pos_counter.sv
// rtl/img_pos_counter.sv - cascaded column/row/channel position counter with last-word flag
module img_pos_counter
    import img_mem_pkg::*;
#(
    parameter  int IMG_W    = IMG_W_DEF,
    parameter  int IMG_H    = IMG_H_DEF,
    parameter  int CHANNELS = 1,
    localparam int COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [COL_W-1:0]  col_o,
    output logic [ROW_W-1:0]  row_o,
    output logic [CHAN_W-1:0] chan_o,
    output logic              last_o
);

    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(IMG_H - 1);
    localparam logic [CHAN_W-1:0] CHAN_MAX = CHAN_W'(CHANNELS - 1);

    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [CHAN_W-1:0] chan_q;

    // Column is the fastest digit; each wrap carries into the next slower digit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q  <= '0;
            row_q  <= '0;
            chan_q <= '0;
        end else if (clear_i) begin
            col_q  <= '0;
            row_q  <= '0;
            chan_q <= '0;
        end else if (advance_i) begin
            if (col_q == COL_MAX) begin
                col_q <= '0;
                if (row_q == ROW_MAX) begin
                    row_q <= '0;
                    if (chan_q == CHAN_MAX) begin
                        chan_q <= '0;
                    end else begin
                        chan_q <= chan_q + 1'b1;
                    end
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign chan_o = chan_q;
    assign last_o = (col_q == COL_MAX) && (row_q == ROW_MAX) && (chan_q == CHAN_MAX);

endmodule

// File: rtl/img_mem_writer.sv
// rtl/img_mem_writer.sv - stream-to-image-RAM write addresser with wait states and frame protocol
module img_mem_writer
    import img_mem_pkg::*;
#(
    parameter  int IMG_W       = IMG_W_DEF,
    parameter  int IMG_H       = IMG_H_DEF,
    parameter  int CHANNELS    = 1,
    parameter  int DATA_W      = PIX_W_DEF,
    parameter  int WAIT_CYCLES = 1,
    localparam int ADDR_W      = (IMG_W * IMG_H * CHANNELS > 1) ? $clog2(IMG_W * IMG_H * CHANNELS) : 1,
    localparam int COL_W       = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int ROW_W       = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [CHAN_W-1:0] chan
);

    if (IMG_W < 1 || IMG_H < 1 || CHANNELS < 1 || WAIT_CYCLES < 0 || WAIT_CYCLES > 255) begin : g_param_check
        $error("img_mem_writer: illegal parameter set");
    end

    localparam logic [7:0] WAIT_LAST = 8'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t            state_q;
    logic [7:0]        wait_cnt_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              hs;
    logic              cnt_clear;
    logic              cnt_advance;
    logic              cnt_last;
    logic [COL_W-1:0]  col_w;
    logic [ROW_W-1:0]  row_w;
    logic [CHAN_W-1:0] chan_w;

    // in_ready_q mirrors state ACCEPT, so this is exactly the accepted-word condition.
    assign hs          = in_valid & in_ready_q;
    // A frame (re)start and any abort both rewind the position; abort also vetoes the advance.
    assign cnt_clear   = abort | (start & ((state_q == IDLE) | (state_q == DONE)));
    assign cnt_advance = hs & ~abort;

    img_pos_counter #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .CHANNELS (CHANNELS)
    ) u_pos (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (cnt_clear),
        .advance_i (cnt_advance),
        .col_o     (col_w),
        .row_o     (row_w),
        .chan_o    (chan_w),
        .last_o    (cnt_last)
    );

    // Frame FSM; every output is registered so the RAM sees a clean, one-cycle-late write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (abort) begin
                state_q    <= IDLE;
                wait_cnt_q <= '0;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            done_q     <= 1'b0;
                            busy_q     <= 1'b1;
                            wait_cnt_q <= '0;
                            if (WAIT_CYCLES > 0) begin
                                state_q    <= WAIT;
                                in_ready_q <= 1'b0;
                            end else begin
                                state_q    <= ACCEPT;
                                in_ready_q <= 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        if (wait_cnt_q == WAIT_LAST) begin
                            wait_cnt_q <= '0;
                            state_q    <= ACCEPT;
                            in_ready_q <= 1'b1;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end
                    ACCEPT: begin
                        if (hs) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= ADDR_W'(lin_addr(32'(chan_w), 32'(row_w), 32'(col_w), IMG_W, IMG_H));
                            mem_wdata_q <= in_data;
                            if (cnt_last) begin
                                state_q    <= DONE;
                                in_ready_q <= 1'b0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                            end else if (WAIT_CYCLES > 0) begin
                                state_q    <= WAIT;
                                in_ready_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign col       = col_w;
    assign row       = row_w;
    assign chan      = chan_w;

endmodule

// File: tb/tb_img_mem_writer.sv
// tb/tb_img_mem_writer.sv - directed self-checking bench for img_mem_writer
module tb_img_mem_writer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Default instance: 28x28x1, one wait cycle
    logic       start1, abort1, in_valid1;
    logic [7:0] in_data1;
    logic       in_ready1, mem_we1, busy1, done1;
    logic [9:0] mem_addr1;
    logic [7:0] mem_wdata1;
    logic [4:0] col1, row1;
    logic [0:0] chan1;

    // Small instance: 4x3x2, no wait cycles
    logic       start2, abort2, in_valid2;
    logic [7:0] in_data2;
    logic       in_ready2, mem_we2, busy2, done2;
    logic [4:0] mem_addr2;
    logic [7:0] mem_wdata2;
    logic [1:0] col2, row2;
    logic [0:0] chan2;

    img_mem_writer dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .busy(busy1), .done(done1), .col(col1), .row(row1), .chan(chan1)
    );

    img_mem_writer #(.IMG_W(4), .IMG_H(3), .CHANNELS(2), .WAIT_CYCLES(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .abort(abort2),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .busy(busy2), .done(done2), .col(col2), .row(row2), .chan(chan2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int hs_idx, wr_idx;
    int we_bad = 0, rdy_bad = 0, gap_bad = 0, rst_we_bad = 0, b2b_bad = 0;
    int cyc_g = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_g++;
    endtask

    task automatic start1_frame();
        start1   = 1'b1;
        in_data1 = 8'd0;
        hs_idx   = 0;
        wr_idx   = 0;
        tick();
        start1 = 1'b0;
        check("start_busy", busy1, 1);
        check("start_done_clr", done1, 0);
        check("start_wait_ready", in_ready1, 0);
        check("start_col", col1, 0);
    endtask

    // Feeds dut1 until `target` writes seen; data word = word index; optional abort on word abort_word.
    task automatic drive1(input int target, input int pct, input int abort_word);
        bit hs;
        bit aborted;
        int cyc;
        int last;
        aborted = 0;
        cyc     = 0;
        last    = -1;
        while (wr_idx < target && !aborted && cyc < 20000) begin
            in_valid1 = ($urandom_range(0, 99) < pct);
            hs = in_valid1 && in_ready1;
            if (hs && hs_idx == abort_word) begin
                abort1  = 1'b1;
                aborted = 1;
            end
            tick();
            abort1 = 1'b0;
            cyc++;
            if (mem_we1 !== (hs && !aborted)) we_bad++;
            if (hs && in_ready1) rdy_bad++;
            if (hs && !aborted) begin
                hs_idx++;
                in_data1 = hs_idx[7:0];
            end
            if (mem_we1) begin
                check("wr_addr", mem_addr1, wr_idx);
                check("wr_data", mem_wdata1, wr_idx & 255);
                if (wr_idx == 783) begin
                    check("last_done", done1, 1);
                    check("last_busy", busy1, 0);
                end
                if (pct == 100 && last >= 0 && cyc - last != 2) gap_bad++;
                last = cyc;
                wr_idx++;
            end
        end
        in_valid1 = 1'b0;
        check("drive_budget", cyc < 20000, 1);
        check("we_vs_handshake", we_bad, 0);
        check("ready_in_wait", rdy_bad, 0);
        check("write_gap", gap_bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hs;
        int h2, n2;
        reset_n = 1'b0;
        {start1, abort1, in_valid1} = '0;
        {start2, abort2, in_valid2} = '0;
        in_data1 = 8'd0;
        in_data2 = 8'h40;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", mem_we1, 0);
        check("rst_addr", mem_addr1, 0);
        check("rst_ready", in_ready1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pos", {col1, row1, chan1}, 0);
        check("rst2_ready", in_ready2, 0);
        reset_n = 1'b1;
        tick();
        check("idle_ready", in_ready1, 0);

        // Full default frame, valid always high
        start1_frame();
        drive1(784, 100, -1);
        check("frameA_writes", wr_idx, 784);
        tick();
        check("frameA_done_hold", done1, 1);
        check("frameA_no_we", mem_we1, 0);
        check("frameA_ready", in_ready1, 0);

        // Small geometry, back-to-back writes and channel wrap
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("b_ready", in_ready2, 1);
        in_valid2 = 1'b1;
        h2 = 0;
        n2 = 0;
        for (int c = 0; c < 40 && n2 < 24; c++) begin
            hs = in_valid2 && in_ready2;
            if (hs && h2 == 11) check("b_pre_wrap", {col2, row2, chan2}, {2'd3, 2'd2, 1'b0});
            tick();
            if (hs) begin
                h2++;
                in_data2 = 8'(h2 + 64);
            end
            if (mem_we2) begin
                check("b_addr", mem_addr2, n2);
                check("b_data", mem_wdata2, n2 + 64);
                if (n2 == 11) check("b_post_wrap", {col2, row2, chan2}, {2'd0, 2'd0, 1'b1});
                if (n2 == 23) check("b_done", {done2, busy2}, 2'b10);
                n2++;
            end else if (n2 > 0 && n2 < 24) begin
                b2b_bad++;
            end
        end
        in_valid2 = 1'b0;
        check("b_writes", n2, 24);
        check("b_back_to_back", b2b_bad, 0);

        // Random valid at 30%
        start1_frame();
        drive1(784, 30, -1);
        check("frameC_writes", wr_idx, 784);

        // Abort coincident with handshake of word 100
        start1_frame();
        drive1(784, 100, 100);
        check("abort_last_wr", wr_idx, 100);
        check("abort_ready", in_ready1, 0);
        check("abort_busy_done", {busy1, done1}, 0);
        check("abort_pos", {col1, row1, chan1}, 0);
        tick();
        check("abort_idle_we", mem_we1, 0);
        check("abort_idle_ready", in_ready1, 0);
        start1_frame();
        drive1(3, 100, -1);
        check("abort_rewrite", wr_idx, 3);

        // Asynchronous reset while word 50 is offered
        drive1(50, 100, -1);
        tick();
        check("pre_rst_ready", in_ready1, 1);
        check("pre_rst_pos", {col1, row1}, {5'd22, 5'd1});
        in_valid1 = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("arst_outs", {in_ready1, mem_we1, busy1, done1}, 0);
        check("arst_addr", mem_addr1, 0);
        check("arst_data", mem_wdata1, 0);
        check("arst_pos", {col1, row1, chan1}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_we1 !== 1'b0) rst_we_bad++;
        end
        check("arst_no_we", rst_we_bad, 0);
        in_valid1 = 1'b0;
        reset_n   = 1'b1;
        tick();
        check("post_rst_idle", {busy1, in_ready1, mem_we1}, 0);
        start1_frame();
        drive1(2, 100, -1);
        check("post_rst_writes", wr_idx, 2);

        // start mid-frame is ignored, start in DONE restarts
        tick();
        check("mid_ready", in_ready1, 1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("mid_start_pos", {col1, row1, chan1}, {5'd2, 5'd0, 1'b0});
        check("mid_start_state", {busy1, in_ready1, done1}, 3'b110);
        drive1(784, 100, -1);
        check("frameF_writes", wr_idx, 784);
        tick();
        check("frameF_done", done1, 1);
        start1_frame();
        drive1(1, 100, -1);
        check("restart_first", wr_idx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/img_mem_writer.md
Name: img_mem_writer

Overview:
- Parametrised write-side addresser for the input image buffer of the digit-recognition accelerator.
- Accepts pixel words over a valid/ready stream and generates registered write address, data and write-enable for the image RAM.
- Walks column, then row, then channel.
- Adds the following:
  - configurable image size and channel count
  - a programmable per-word wait state
  - a start/abort/done frame protocol

Parameters:
- IMG_W, 28, pixels per row.
- IMG_H, 28, rows per image.
- CHANNELS, 1, image planes stored back to back.
- DATA_W, 8, pixel word width.
- WAIT_CYCLES, 1, idle cycles after each write before the next word is accepted; 0 allows back-to-back writes.
- ADDR_W (localparam), $clog2(IMG_W*IMG_H*CHANNELS), memory address width.

Ports:
- clk, in, 1, system clock, rising edge.
- reset_n, in, 1, asynchronous, active-low reset.
- start, in, 1, single-cycle pulse that begins a frame.
- abort, in, 1, synchronous frame cancel.
- in_valid, in, 1, pixel word present.
- in_data, in, DATA_W, pixel word.
- in_ready, out, 1, block accepts in_data this cycle.
- mem_we, out, 1, image RAM write enable (one cycle per word).
- mem_addr, out, ADDR_W, image RAM address.
- mem_wdata, out, DATA_W, image RAM write data.
- busy, out, 1, frame in progress.
- done, out, 1, frame complete (sticky).
- col, out, $clog2(IMG_W), current column.
- row, out, $clog2(IMG_H), current row.
- chan, out, max(1,$clog2(CHANNELS)), current channel.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state IDLE
  - col, row and chan all 0
  - mem_addr, mem_wdata, mem_we, in_ready, busy and done all 0
- States:
  - IDLE: in_ready=0, busy=0.
    - start moves to WAIT if WAIT_CYCLES>0, otherwise to ACCEPT.
    - Entering from IDLE clears done and all counters.
  - WAIT: in_ready=0, busy=1.
    - A cycle counter runs from 0 to WAIT_CYCLES-1, then moves to ACCEPT.
  - ACCEPT: in_ready=1, busy=1.
    - A handshake occurs when in_valid and in_ready are both 1.
    - On a handshake, the next cycle has mem_we=1, mem_addr=chan*IMG_W*IMG_H + row*IMG_W + col and mem_wdata=in_data. Latency is exactly 1 cycle.
    - After a handshake: go to DONE if it was the last word, else to WAIT (WAIT_CYCLES>0) or stay in ACCEPT (WAIT_CYCLES=0).
    - With no valid, hold the state and counters indefinitely.
  - DONE: in_ready=0, busy=0, done=1.
    - done is held until start or abort.
    - start in DONE restarts the frame as from IDLE.
- Counter advance on each handshake:
  - col increments.
  - When col==IMG_W-1, col wraps to 0 and row increments.
  - When row==IMG_H-1 and col wraps, row wraps to 0 and chan increments.
  - The last word is col==IMG_W-1, row==IMG_H-1 and chan==CHANNELS-1. For 28x28x1 the final address is 783 (0x30F).
- mem_we:
  - Asserted only in the cycle after a handshake.
  - Never asserted for two cycles when WAIT_CYCLES>0.
  - Asserted exactly once for the last word, in the first DONE cycle; done rises in that same cycle.
- start while busy=1 is ignored.
- abort:
  - Takes priority over start and over a handshake in the same cycle. The handshaked word is not written, and in_ready is 0 from the next cycle.
  - Returns to IDLE with counters cleared and done=0.
  - Any pending mem_we already registered still completes.
- Arithmetic:
  - Counters are unsigned.
  - The address is computed in ADDR_W bits with no overflow for legal parameters.
- Elaboration checks: IMG_W>=1, IMG_H>=1, CHANNELS>=1, WAIT_CYCLES<256.
- Reset asserted mid-frame aborts immediately (asynchronous). No write occurs after reset_n falls.

Decomposition:
- Package img_mem_pkg holds:
  - typedef enum state_t {IDLE, WAIT, ACCEPT, DONE}
  - default image constants IMG_W_DEF=28, IMG_H_DEF=28, PIX_W_DEF=8
  - a function computing the linear address from (chan, row, col)
- Sub-module img_pos_counter: the cascaded col/row/chan wrap counter with an advance input and a last flag. It is reusable by the read-side and feature-map addressers.

Test Plan:
- Default parameters; start, then in_valid held high for 784 words with data=addr[7:0]:
  - mem_we pulses 784 times, every 2nd cycle (WAIT_CYCLES=1).
  - Addresses run 0..783.
  - done=1 on the cycle of the write to 783; busy=0.
- WAIT_CYCLES=0, IMG_W=4, IMG_H=3, CHANNELS=2; continuous valid:
  - 24 back-to-back writes to addresses 0..23.
  - (col,row,chan) wraps (3,2,0)->(0,0,1) between addresses 11 and 12.
- in_valid toggled randomly 30% of the time (default parameters):
  - Address sequence is still contiguous 0..783 with no duplicates.
  - in_ready is never 1 during a WAIT cycle.
- abort asserted coincident with the handshake of word 100:
  - The last write is address 99; IDLE next cycle; counters=0, done=0.
  - A following start rewrites from address 0.
- reset_n pulled low while in ACCEPT at address 50:
  - All outputs are 0 asynchronously; no mem_we after reset.
  - After release, start behaves as a fresh frame.
- start pulsed mid-frame (ignored), then start in DONE:
  - The first is ignored with no counter change.
  - The second clears done and restarts at address 0.
